// File: rtl/dds_tone_meas_pkg.sv
// rtl/dds_tone_meas_pkg.sv - shared constants and state encodings for the DDS tone meter
package dds_tone_meas_pkg;

    localparam int DW_DEF        = 8;
    localparam int ACC_W_DEF     = 8;
    localparam int GATE_LOG2_DEF = 2;
    localparam int HYST_DEF      = 16;
    localparam int MID_DEF       = 1 << (DW_DEF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_REPORT
    } meas_state_t;

    typedef enum logic {
        DET_LO,
        DET_HI
    } det_state_t;

    // Gate length in valid samples for a given accumulator width and gate exponent.
    function automatic int gate_len(input int acc_w, input int gate_log2);
        return 1 << (acc_w + gate_log2);
    endfunction

endpackage

// File: rtl/dds_tone_meas_if.sv
// rtl/dds_tone_meas_if.sv - sample input and measurement output bundle
interface dds_tone_meas_if
    import dds_tone_meas_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic             sample_vld;
    logic [DW-1:0]    sample;
    logic [ACC_W-1:0] frq_est;
    logic [ACC_W-1:0] pha_est;
    logic             meas_vld;
    logic             locked;

    modport master (
        output sample_vld, sample,
        input  frq_est, pha_est, meas_vld, locked
    );

    modport slave (
        input  sample_vld, sample,
        output frq_est, pha_est, meas_vld, locked
    );
endinterface

// File: rtl/dds_tone_meas_xing_det.sv
// rtl/dds_tone_meas_xing_det.sv - hysteresis rising-crossing detector about mid-scale
module dds_tone_meas_xing_det
    import dds_tone_meas_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int HYST = HYST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_vld,
    input  logic [DW-1:0] sample,
    output logic          xing,
    output logic          det_lo
);
    localparam int            MID   = 1 << (DW - 1);
    localparam logic [DW-1:0] HI_TH = DW'(MID + HYST);
    localparam logic [DW-1:0] LO_TH = DW'(MID - HYST);

    det_state_t state;

    // The pulse is combinational so the counter logic sees it in the same cycle as the sample.
    always_comb begin
        xing   = sample_vld && (state == DET_LO) && (sample >= HI_TH);
        det_lo = (state == DET_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DET_LO;
        end else if (sample_vld) begin
            if (state == DET_LO && sample >= HI_TH) begin
                state <= DET_HI;
            end else if (state == DET_HI && sample <= LO_TH) begin
                state <= DET_LO;
            end
        end
    end
endmodule

// File: rtl/dds_tone_meas.sv
// rtl/dds_tone_meas.sv - recovers the DDS frequency word and first-crossing phase per gate
module dds_tone_meas
    import dds_tone_meas_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int GATE_LOG2 = GATE_LOG2_DEF,
    parameter int HYST      = HYST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    dds_tone_meas_if.slave  bus
);
    localparam int                SCNT_W = ACC_W + GATE_LOG2;
    localparam logic [SCNT_W-1:0] LAST   = SCNT_W'(gate_len(ACC_W, GATE_LOG2) - 1);
    localparam int                RND    = (1 << GATE_LOG2) >> 1;

    logic [DW-1:0]     s_reg;
    logic              v_reg;
    logic              xing;
    logic              det_lo;
    meas_state_t       state;
    logic [SCNT_W-1:0] scnt;
    logic [SCNT_W-1:0] xcnt;
    logic              first_seen;
    logic [ACC_W-1:0]  pha_tmp;
    logic [ACC_W-1:0]  frq_q;
    logic [ACC_W-1:0]  pha_q;
    logic              meas_vld_q;
    logic              locked_q;
    logic [SCNT_W:0]   frq_sum;
    logic [ACC_W-1:0]  frq_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= '0;
            v_reg <= 1'b0;
        end else begin
            s_reg <= bus.sample;
            v_reg <= bus.sample_vld;
        end
    end

    dds_tone_meas_xing_det #(
        .DW   (DW),
        .HYST (HYST)
    ) u_det (
        .clk        (clk),
        .rst        (rst),
        .sample_vld (v_reg),
        .sample     (s_reg),
        .xing       (xing),
        .det_lo     (det_lo)
    );

    // Rounded crossings-per-period; xcnt never exceeds G/2, so the sum cannot overflow.
    always_comb begin
        frq_sum = {1'b0, xcnt} + (SCNT_W + 1)'(RND);
        frq_new = ACC_W'(frq_sum >> GATE_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            scnt       <= '0;
            xcnt       <= '0;
            first_seen <= 1'b0;
            pha_tmp    <= '0;
            frq_q      <= '0;
            pha_q      <= '0;
            meas_vld_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            meas_vld_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (det_lo) begin
                        scnt       <= '0;
                        xcnt       <= '0;
                        first_seen <= 1'b0;
                        state      <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (v_reg) begin
                        scnt <= scnt + SCNT_W'(1);
                        if (scnt == LAST) begin
                            state <= ST_REPORT;
                        end
                    end
                    if (xing) begin
                        xcnt <= xcnt + SCNT_W'(1);
                        if (!first_seen) begin
                            pha_tmp    <= scnt[ACC_W-1:0];
                            first_seen <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    frq_q      <= frq_new;
                    pha_q      <= first_seen ? pha_tmp : '0;
                    meas_vld_q <= 1'b1;
                    locked_q   <= (frq_new == frq_q) && (frq_new != '0);
                    // The sample arriving now is index 0 of the next gate and must not be dropped.
                    xcnt       <= xing ? SCNT_W'(1) : '0;
                    first_seen <= xing;
                    if (xing) begin
                        pha_tmp <= scnt[ACC_W-1:0];
                    end
                    if (v_reg) begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                    state <= ST_ACQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.frq_est  = frq_q;
    assign bus.pha_est  = pha_q;
    assign bus.meas_vld = meas_vld_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_dds_tone_meas.sv
// tb/tb_dds_tone_meas.sv - directed self-checking bench for dds_tone_meas
module tb_dds_tone_meas;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulse_err = 0;
    bit   prev_mv = 1'b0;
    logic [7:0] ph = 8'd0;
    bit   alt = 1'b0;

    int rpt_frq[$];
    int rpt_pha[$];
    int rpt_lock[$];
    int rpt_cyc[$];

    dds_tone_meas_if #(.DW(8), .ACC_W(8)) bus ();

    dds_tone_meas #(
        .DW        (8),
        .ACC_W     (8),
        .GATE_LOG2 (2),
        .HYST      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.meas_vld === 1'b1) begin
            rpt_frq.push_back(int'(bus.frq_est));
            rpt_pha.push_back(int'(bus.pha_est));
            rpt_lock.push_back(int'(bus.locked));
            rpt_cyc.push_back(cyc);
            if (prev_mv) pulse_err++;
        end
        prev_mv = (bus.meas_vld === 1'b1);
    end

    function automatic logic [7:0] sine_at(input logic [7:0] p);
        real a;
        a = 2.0 * 3.14159265358979 * real'(p) / 256.0;
        return 8'(128 + $rtoi(127.0 * $sin(a)));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // mode: 0 sine, 1 sine with +/-8 noise, 2 constant mid-scale, 3 alternating 0/255
    task automatic drive(input int n, input int k, input int mode, input bit half);
        int v;
        for (int i = 0; i < n; i++) begin
            if (half) begin
                @(negedge clk);
                bus.sample_vld = 1'b0;
            end
            @(negedge clk);
            case (mode)
                0: v = int'(sine_at(ph));
                1: begin
                    v = int'(sine_at(ph)) + int'($urandom_range(16)) - 8;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                end
                2: v = 128;
                default: v = alt ? 255 : 0;
            endcase
            bus.sample     = 8'(v);
            bus.sample_vld = 1'b1;
            ph  = ph + 8'(k);
            alt = ~alt;
        end
    endtask

    task automatic wait_reports(input int n);
        int t = 0;
        while (rpt_frq.size() < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("report_count", rpt_frq.size(), n);
    endtask

    initial begin
        int exp_f[13] = '{1, 1, 1, 1, 1, 2, 2, 0, 0, 4, 4, 128, 128};
        int exp_p[13] = '{6, 6, 6, -1, -1, 3, 3, 0, 0, 2, 2, 1, -1};
        int exp_l[13] = '{0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0};
        int r_cyc;

        bus.sample     = 8'd128;
        bus.sample_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_frq_est", int'(bus.frq_est), 0);
        chk("reset_pha_est", int'(bus.pha_est), 0);
        chk("reset_meas_vld", int'(bus.meas_vld), 0);
        chk("reset_locked", int'(bus.locked), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        ph = 8'd0;
        drive(3 * 1024, 1, 0, 1'b0);
        drive(2 * 1024, 1, 1, 1'b0);
        ph = 8'd0;
        drive(2 * 1024, 2, 0, 1'b0);
        drive(2 * 1024, 0, 2, 1'b0);
        ph = 8'd0;
        drive(2 * 1024, 4, 0, 1'b1);
        alt = 1'b0;
        drive(1024 + 500, 0, 3, 1'b0);

        @(negedge clk);
        rst            = 1'b1;
        bus.sample_vld = 1'b0;
        @(negedge clk);
        r_cyc = cyc;
        chk("midgate_rst_frq_est", int'(bus.frq_est), 0);
        chk("midgate_rst_pha_est", int'(bus.pha_est), 0);
        chk("midgate_rst_meas_vld", int'(bus.meas_vld), 0);
        chk("midgate_rst_locked", int'(bus.locked), 0);
        rst = 1'b0;
        drive(1024, 0, 3, 1'b0);
        @(negedge clk);
        bus.sample_vld = 1'b0;

        wait_reports(13);
        for (int i = 0; i < 13; i++) begin
            if (i < rpt_frq.size()) begin
                chk($sformatf("r%0d_frq_est", i), rpt_frq[i], exp_f[i]);
                chk($sformatf("r%0d_locked", i), rpt_lock[i], exp_l[i]);
                if (exp_p[i] >= 0) chk($sformatf("r%0d_pha_est", i), rpt_pha[i], exp_p[i]);
            end
        end
        if (rpt_cyc.size() >= 13) begin
            chk("duty_report_spacing", rpt_cyc[10] - rpt_cyc[9], 2048);
            chk("rearm_report_latency", rpt_cyc[12] - r_cyc, 1027);
        end
        chk("meas_vld_width", pulse_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
